// File: rtl/prng_sched.sv
// prng_sched: sequencer for an external 16-bit data LFSR and 8-bit control LFSR.
// It seeds both LFSRs, runs a warm-up burst of data steps, then issues timed
// data steps. It hands out random bytes to two requesters in round-robin order
// and forces a refresh step after every grant.
// Ports:
//   CLK, reset            clock, asynchronous active-high reset
//   en                    block enable (low -> IDLE)
//   seed_wr, seed_in      reseed strobe and new 16-bit seed
//   req                   level-held random-byte requests
//   mux_byte              byte from the LFSR datapath
//   lfsr_load, lfsr_seed  load pulse and seed for both LFSRs
//   data_step, ctrl_step  advance pulses for the data / control LFSR
//   gnt, rnd_byte         one-hot grant and the byte valid alongside it
//   busy                  high while seeding or warming up
module prng_sched #(
  parameter logic [23:0] DATA_DIV  = 24'd10_000_000,
  parameter logic [7:0]  CTRL_DIV  = 8'd8,
  parameter logic [7:0]  WARMUP    = 8'd16,
  parameter logic [15:0] SEED_INIT = 16'hACE1
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        en,
  input  logic        seed_wr,
  input  logic [15:0] seed_in,
  input  logic [1:0]  req,
  input  logic [7:0]  mux_byte,
  output logic        lfsr_load,
  output logic [15:0] lfsr_seed,
  output logic        data_step,
  output logic        ctrl_step,
  output logic [1:0]  gnt,
  output logic [7:0]  rnd_byte,
  output logic        busy
);

  localparam logic [23:0] TIMER_TC = DATA_DIV - 24'd1;
  localparam logic [7:0]  CTRL_TC  = CTRL_DIV - 8'd1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEED    = 3'd1,
    WARM    = 3'd2,
    RUN     = 3'd3,
    REFRESH = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] timer_q, timer_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic [7:0]  warm_q, warm_d;
  logic        rr_q, rr_d;
  logic [15:0] seed_q, seed_d;
  logic        load_q, load_d;
  logic        dstep_q, dstep_d;
  logic        cstep_q, cstep_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [7:0]  rnd_q, rnd_d;
  logic        busy_q, busy_d;
  logic        timed_step;
  logic        gidx;

  // State and registered outputs
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= 24'd0;
      ctrl_q  <= 8'd0;
      warm_q  <= 8'd0;
      rr_q    <= 1'b0;
      seed_q  <= SEED_INIT;
      load_q  <= 1'b0;
      dstep_q <= 1'b0;
      cstep_q <= 1'b0;
      gnt_q   <= 2'b00;
      rnd_q   <= 8'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ctrl_q  <= ctrl_d;
      warm_q  <= warm_d;
      rr_q    <= rr_d;
      seed_q  <= seed_d;
      load_q  <= load_d;
      dstep_q <= dstep_d;
      cstep_q <= cstep_d;
      gnt_q   <= gnt_d;
      rnd_q   <= rnd_d;
      busy_q  <= busy_d;
    end
  end

  // Next state and next-cycle outputs; outputs describe the state being entered
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    ctrl_d     = ctrl_q;
    warm_d     = warm_q;
    rr_d       = rr_q;
    seed_d     = seed_q;
    load_d     = 1'b0;
    dstep_d    = 1'b0;
    cstep_d    = 1'b0;
    gnt_d      = 2'b00;
    rnd_d      = rnd_q;
    timed_step = 1'b0;
    gidx       = 1'b0;

    if (!en) begin
      state_d = IDLE;
      timer_d = 24'd0;
      ctrl_d  = 8'd0;
      warm_d  = 8'd0;
    end else if (seed_wr) begin
      seed_d  = seed_in;
      state_d = SEED;
      load_d  = 1'b1;
      timer_d = 24'd0;
      ctrl_d  = 8'd0;
      warm_d  = 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SEED;
          load_d  = 1'b1;
        end
        SEED: begin
          timer_d = 24'd0;
          if (WARMUP == 8'd0) begin
            state_d = RUN;
          end else begin
            state_d = WARM;
            dstep_d = 1'b1;
            warm_d  = 8'd1;
          end
        end
        WARM: begin
          if (warm_q >= WARMUP) begin
            state_d = RUN;
            timer_d = 24'd0;
            warm_d  = 8'd0;
          end else begin
            dstep_d = 1'b1;
            warm_d  = warm_q + 8'd1;
          end
        end
        RUN, REFRESH: begin
          if (state_q == RUN && req != 2'b00) begin
            // Prefer the pointed-to requester, else the other one
            gidx        = req[rr_q] ? rr_q : ~rr_q;
            gnt_d[gidx] = 1'b1;
            rr_d        = ~gidx;
            rnd_d       = mux_byte;
            state_d     = REFRESH;
            // The refresh step absorbs any coincident terminal count
            timer_d     = 24'd0;
            timed_step  = 1'b1;
          end else begin
            state_d = RUN;
            if (timer_q == TIMER_TC) begin
              timer_d    = 24'd0;
              timed_step = 1'b1;
            end else begin
              timer_d = timer_q + 24'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Control LFSR advances once per CTRL_DIV run-phase data steps
    if (timed_step) begin
      dstep_d = 1'b1;
      if (ctrl_q == CTRL_TC) begin
        cstep_d = 1'b1;
        ctrl_d  = 8'd0;
      end else begin
        ctrl_d = ctrl_q + 8'd1;
      end
    end

    busy_d = (state_d == SEED) || (state_d == WARM);
  end

  assign lfsr_load = load_q;
  assign lfsr_seed = seed_q;
  assign data_step = dstep_q;
  assign ctrl_step = cstep_q;
  assign gnt       = gnt_q;
  assign rnd_byte  = rnd_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_prng_sched.sv
// Testbench for prng_sched: scenario tasks plus randomized traffic, checked
// against a behavioural model of the sequencing rules.
module tb_prng_sched;

  localparam logic [23:0] P_DDIV = 24'd4;
  localparam logic [7:0]  P_CDIV = 8'd2;
  localparam logic [7:0]  P_WARM = 8'd3;
  localparam logic [15:0] SEED0  = 16'hACE1;

  localparam int M_IDLE = 0, M_SEED = 1, M_WARM = 2, M_RUN = 3, M_REFRESH = 4;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        seed_wr = 1'b0;
  logic [15:0] seed_in = 16'd0;
  logic [1:0]  req = 2'b00;
  logic [7:0]  mux_byte = 8'd0;
  logic        lfsr_load, data_step, ctrl_step, busy;
  logic [15:0] lfsr_seed;
  logic [1:0]  gnt;
  logic [7:0]  rnd_byte;

  always #5 CLK = ~CLK;

  prng_sched #(
    .DATA_DIV (P_DDIV),
    .CTRL_DIV (P_CDIV),
    .WARMUP   (P_WARM),
    .SEED_INIT(SEED0)
  ) dut (
    .CLK      (CLK),
    .reset    (reset),
    .en       (en),
    .seed_wr  (seed_wr),
    .seed_in  (seed_in),
    .req      (req),
    .mux_byte (mux_byte),
    .lfsr_load(lfsr_load),
    .lfsr_seed(lfsr_seed),
    .data_step(data_step),
    .ctrl_step(ctrl_step),
    .gnt      (gnt),
    .rnd_byte (rnd_byte),
    .busy     (busy)
  );

  // Behavioural model: mode, cycles since the last run-phase timer restart,
  // remaining warm-up steps, and run-phase steps since the last clear.
  int          m_mode, m_since, m_warm_left, m_nsteps, m_ptr;
  logic [15:0] m_seed;
  logic [7:0]  m_rnd;
  logic        e_load, e_ds, e_cs, e_busy;
  logic [1:0]  e_gnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  function automatic logic [29:0] exp_vec();
    return {e_load, m_seed, e_ds, e_cs, e_gnt, m_rnd, e_busy};
  endfunction

  function automatic logic [29:0] dut_vec();
    return {lfsr_load, lfsr_seed, data_step, ctrl_step, gnt, rnd_byte, busy};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_since = 0; m_warm_left = 0; m_nsteps = 0; m_ptr = 0;
    m_seed = SEED0; m_rnd = 8'd0;
    e_load = 1'b0; e_ds = 1'b0; e_cs = 1'b0; e_busy = 1'b0; e_gnt = 2'b00;
  endtask

  // Predict the outputs seen after the coming clock edge
  task automatic model_step();
    bit run_step;
    int g;
    run_step = 1'b0;
    e_load = 1'b0; e_ds = 1'b0; e_cs = 1'b0; e_gnt = 2'b00;
    if (!en) begin
      m_mode = M_IDLE; m_since = 0; m_nsteps = 0;
    end else if (seed_wr) begin
      m_seed = seed_in; m_mode = M_SEED; e_load = 1'b1; m_since = 0; m_nsteps = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          m_mode = M_SEED; e_load = 1'b1;
        end
        M_SEED, M_WARM: begin
          if (m_mode == M_SEED) m_warm_left = int'(P_WARM);
          if (m_warm_left == 0) begin
            m_mode = M_RUN; m_since = 0;
          end else begin
            m_mode = M_WARM; e_ds = 1'b1; m_warm_left--;
          end
        end
        default: begin
          if (m_mode == M_RUN && req != 2'b00) begin
            g = req[m_ptr] ? m_ptr : 1 - m_ptr;
            e_gnt = (g == 0) ? 2'b01 : 2'b10;
            m_ptr = 1 - g;
            m_rnd = mux_byte;
            m_mode = M_REFRESH;
            m_since = 0;
            run_step = 1'b1;
          end else begin
            m_mode = M_RUN;
            m_since++;
            if (m_since == int'(P_DDIV)) begin
              m_since = 0;
              run_step = 1'b1;
            end
          end
        end
      endcase
    end
    if (run_step) begin
      e_ds = 1'b1;
      m_nsteps++;
      e_cs = ((m_nsteps % int'(P_CDIV)) == 0);
    end
    e_busy = (m_mode == M_SEED) || (m_mode == M_WARM);
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    model_reset();
    #3;
    n_tests++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_hold got=%h exp=%h", dut_vec(), exp_vec());
    end
    @(posedge CLK);
    #1;
    reset = 1'b0;
    n_tests++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_release got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_startup();
    int ds_cnt;
    ds_cnt = 0;
    en = 1'b1;
    req = 2'b00;
    for (int i = 1; i <= 24; i++) begin
      mux_byte = 8'($urandom);
      tick();
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL startup_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      if (i == 1) begin
        n_tests++;
        if ({lfsr_load, lfsr_seed} !== {1'b1, 16'hACE1}) begin
          n_fail++;
          $display("FAIL startup_load got=%b/%h exp=1/ace1", lfsr_load, lfsr_seed);
        end
      end
      if (i >= 2 && i <= 4 && data_step === 1'b1) ds_cnt++;
      if (i == 4) begin
        n_tests++;
        if (ds_cnt != 3) begin
          n_fail++;
          $display("FAIL startup_warm_steps got=%0d exp=3", ds_cnt);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] g_q[$];
    logic [1:0] want[4];
    want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b01; want[3] = 2'b10;
    req = 2'b11;
    for (int i = 0; i < 12; i++) begin
      mux_byte = 8'($urandom);
      tick();
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL rr_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      if (gnt !== 2'b00) g_q.push_back(gnt);
    end
    req = 2'b00;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (g_q.size() <= i || g_q[i] !== want[i]) begin
        n_fail++;
        $display("FAIL rr_order idx=%0d got=%b exp=%b", i,
                 (g_q.size() > i) ? g_q[i] : 2'bxx, want[i]);
      end
    end
  endtask

  task automatic test_grant_at_terminal();
    int guard;
    int ds_cnt;
    req = 2'b00;
    guard = 0;
    while (!(m_mode == M_RUN && m_since == int'(P_DDIV) - 1) && guard < 20) begin
      tick();
      guard++;
    end
    n_tests++;
    if (guard >= 20) begin
      n_fail++;
      $display("FAIL term_timeout got=%0d cycles exp=<20", guard);
    end
    req = 2'b01;
    mux_byte = 8'($urandom);
    tick();
    req = 2'b00;
    n_tests++;
    if ({gnt, data_step, rnd_byte} !== {2'b01, 1'b1, m_rnd} || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL term_grant got=%h exp=%h", dut_vec(), exp_vec());
    end
    ds_cnt = 0;
    for (int i = 0; i < int'(P_DDIV) - 1; i++) begin
      tick();
      if (data_step === 1'b1) ds_cnt++;
    end
    n_tests++;
    if (ds_cnt != 0) begin
      n_fail++;
      $display("FAIL term_single got=%0d extra steps exp=0", ds_cnt);
    end
    tick();
    n_tests++;
    if (data_step !== 1'b1 || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL term_restart got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_seed_warm();
    int ds_cnt;
    logic bad_gnt;
    seed_wr = 1'b1;
    seed_in = 16'($urandom);
    tick();
    seed_wr = 1'b0;
    tick();
    req = 2'b01;
    seed_wr = 1'b1;
    seed_in = 16'h1234;
    tick();
    seed_wr = 1'b0;
    n_tests++;
    if ({gnt, lfsr_load, lfsr_seed} !== {2'b00, 1'b1, 16'h1234} || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL seedwr_load got=%h exp=%h", dut_vec(), exp_vec());
    end
    ds_cnt = 0;
    bad_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (data_step === 1'b1) ds_cnt++;
      if (gnt !== 2'b00) bad_gnt = 1'b1;
    end
    n_tests++;
    if (ds_cnt != 3 || bad_gnt) begin
      n_fail++;
      $display("FAIL seed_rewarm got=%0d steps gnt_seen=%b exp=3 steps gnt_seen=0", ds_cnt, bad_gnt);
    end
    tick();
    req = 2'b00;
    n_tests++;
    if (gnt !== 2'b01 || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL seed_gnt got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_en_drop();
    for (int i = 0; i < 3; i++) tick();
    en = 1'b0;
    tick();
    n_tests++;
    if ({lfsr_load, data_step, ctrl_step, gnt, busy} !== 6'd0 || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL endrop_zero got=%h exp=%h", dut_vec(), exp_vec());
    end
    tick();
    en = 1'b1;
    tick();
    n_tests++;
    if ({lfsr_load, lfsr_seed, busy} !== {1'b1, 16'h1234, 1'b1} || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL en_reseed got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      en       = ($urandom % 50) != 0;
      seed_wr  = ($urandom % 40) == 0;
      seed_in  = 16'($urandom);
      req      = (($urandom % 3) == 0) ? 2'b00 : 2'($urandom);
      mux_byte = 8'($urandom);
      tick();
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
    end
    en = 1'b1;
    seed_wr = 1'b0;
    req = 2'b00;
  endtask

  task automatic test_reset_refresh();
    int guard;
    req = 2'b10;
    guard = 0;
    while (gnt === 2'b00 && guard < 30) begin
      tick();
      guard++;
    end
    req = 2'b00;
    n_tests++;
    if (guard >= 30) begin
      n_fail++;
      $display("FAIL rstref_timeout got=%0d cycles exp=<30", guard);
    end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_refresh got=%h exp=%h", dut_vec(), exp_vec());
    end
    @(posedge CLK);
    #1;
    n_tests++;
    if (data_step !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_refresh_hold got=%h exp=%h", dut_vec(), exp_vec());
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_round_robin();
    test_grant_at_terminal();
    test_seed_warm();
    test_en_drop();
    test_random();
    test_reset_refresh();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prng_sched.md
PRNG_SCHED -- requirements
Module: prng_sched

Interface
REQ-001 Parameter: DATA_DIV, default 24'd10_000_000, CLK cycles between timed data-LFSR steps (legal range 2..2^24-1).
REQ-002 Parameter: CTRL_DIV, default 8'd8, number of data steps per control-LFSR step (legal range 1..255).
REQ-003 Parameter: WARMUP, default 8'd16, back-to-back data steps issued after every seed load (legal range 0..255).
REQ-004 Parameter: SEED_INIT, default 16'hACE1, seed in effect after reset.
REQ-005 Port: CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-006 Port: reset, input, 1, asynchronous active-high reset.
REQ-007 Port: en, input, 1, block enable; low forces IDLE synchronously.
REQ-008 Port: seed_wr, input, 1, single-cycle strobe that captures seed_in and reseeds.
REQ-009 Port: seed_in, input, 16, new seed; [15:0] go to the data LFSR, [7:0] go to the control LFSR.
REQ-010 Port: req, input, 2, per-requester random-byte requests, level-held until granted.
REQ-011 Port: mux_byte, input, 8, combinational byte from the LFSR/mux datapath.
REQ-012 Port: lfsr_load, output, 1, one-cycle pulse; the datapath loads lfsr_seed into both LFSRs.
REQ-013 Port: lfsr_seed, output, 16, registered seed value.
REQ-014 Port: data_step, output, 1, one-cycle enable that advances the 16-bit LFSR.
REQ-015 Port: ctrl_step, output, 1, one-cycle enable that advances the 8-bit LFSR.
REQ-016 Port: gnt, output, 2, one-hot one-cycle grant.
REQ-017 Port: rnd_byte, output, 8, registered byte valid in the gnt cycle.
REQ-018 Port: busy, output, 1, high in the SEED and WARM states.

Function
REQ-019 FSM states are IDLE, SEED, WARM, RUN, REFRESH.
- IDLE -> SEED when en=1.
- SEED lasts 1 cycle with lfsr_load=1, then -> WARM.
- WARM issues data_step every cycle for WARMUP cycles, then -> RUN; WARMUP=0 goes straight to RUN.
REQ-020 RUN timer: a 24-bit counter counts 0..DATA_DIV-1. At terminal count it pulses data_step for 1 cycle and wraps to 0.
REQ-021 Control stepping: an 8-bit counter counts data_steps issued in RUN/REFRESH. On the CTRL_DIV-th step it pulses ctrl_step in the same cycle and wraps to 0. WARM steps never increment it.
REQ-022 Arbitration: in RUN, with req!=0 and no seed_wr, exactly one requester gets gnt for 1 cycle.
- Round-robin order; pointer prefers req[0] after reset.
- Pointer moves past the granted requester.
- A sole requester is granted every opportunity.
REQ-023 rnd_byte is registered from mux_byte in the grant decision cycle, so it is valid coincident with gnt. rnd_byte holds its value otherwise.
REQ-024 After every grant the FSM enters REFRESH for 1 cycle.
- REFRESH forces data_step=1 and restarts the timer at 0.
- REFRESH blocks grants, so consecutive grants are at least 2 cycles apart.
- The FSM then returns to RUN.
REQ-025 A timer terminal count that coincides with REFRESH yields a single data_step, not two.
REQ-026 seed_wr in any state with en=1 captures seed_in into lfsr_seed and enters SEED next cycle, aborting WARM/RUN/REFRESH.
- Both counters clear.
- A grant does not occur in the seed_wr cycle.
- seed_wr in the SEED cycle restarts SEED with the new seed.
REQ-027 en=0 from any state: next cycle IDLE, all pulse outputs 0, counters cleared.
- lfsr_seed and the rr pointer are retained.
- When en rises again, the FSM reseeds via SEED with the retained lfsr_seed.
REQ-028 data_step, ctrl_step, lfsr_load, and gnt are all registered outputs, glitch-free.

Reset
REQ-029 While reset=1, the block immediately holds the following values:
- state=IDLE; all counters=0.
- lfsr_seed=SEED_INIT; rr pointer=requester 0.
- lfsr_load, data_step, ctrl_step, gnt, busy, rnd_byte all 0.
REQ-030 Deassertion of reset is observed on the next CLK edge. No output changes in the same cycle that reset is deasserted.

Verification
REQ-031 Startup, DATA_DIV=4, CTRL_DIV=2, WARMUP=3: reset, then en=1 -> one lfsr_load with lfsr_seed=16'hACE1, then 3 consecutive data_step, then data_step every 4 cycles, with ctrl_step on every 2nd timed step.
REQ-032 req=2'b11 held in RUN -> gnt sequence 01, 10, 01, 10 with exactly one REFRESH data_step between grants; rnd_byte equals mux_byte sampled in each decision cycle.
REQ-033 Grant issued when the timer is at DATA_DIV-1 -> exactly one data_step in the REFRESH cycle, and the timer restarts at 0.
REQ-034 seed_wr=1 with seed_in=16'h1234 during WARM, with req=2'b01 pending -> no gnt; lfsr_load next cycle with lfsr_seed=16'h1234; full WARMUP is repeated; gnt=01 only after RUN is reached.
REQ-035 en dropped mid-RUN, then re-raised -> outputs 0 the next cycle, then SEED with the retained seed; reset asserted mid-REFRESH -> all outputs 0 immediately, with no data_step pulse.
